// File: rtl/n101_subsys_icb_arb2_pkg.sv
// Shared constants and types for the two-master ICB command arbiter.
package n101_subsys_icb_arb2_pkg;

   localparam int N101_ADDR_SIZE = 32;
   localparam int N101_XLEN      = 32;

   // Master IDs as recorded in the response-routing FIFO.
   localparam logic ARB_ID_M0 = 1'b0;
   localparam logic ARB_ID_M1 = 1'b1;

   // Bundle of command fields so the grant mux stays a single select.
   typedef struct packed {
      logic [N101_ADDR_SIZE-1:0] addr;
      logic                      read;
      logic [N101_XLEN-1:0]      wdata;
      logic [N101_XLEN/8-1:0]    wmask;
      logic                      lock;
      logic                      excl;
      logic [1:0]                size;
   } icb_cmd_t;

endpackage

// File: rtl/n101_subsys_arb_idfifo.sv
// In-order 1-bit master-ID FIFO; full/empty flags, no bypass in either direction.
module n101_subsys_arb_idfifo #(
   parameter int OUTS_DEPTH = 2,
   parameter int OUTS_PTR_W = $clog2(OUTS_DEPTH) + 1
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic push_id,
   input  logic pop,
   output logic pop_id,
   output logic full,
   output logic empty
);

   // A depth of 1 gives a zero-width index; keep at least one index bit.
   localparam int IDX_W = (OUTS_PTR_W > 1) ? (OUTS_PTR_W - 1) : 1;

   logic             mem [OUTS_DEPTH];
   logic [IDX_W:0]   wr_ptr;
   logic [IDX_W:0]   rd_ptr;
   logic             push_en;
   logic             pop_en;

   // Advance a {wrap, index} pointer, wrapping the index at OUTS_DEPTH.
   function automatic logic [IDX_W:0] ptr_inc(input logic [IDX_W:0] p);
      if (p[IDX_W-1:0] == IDX_W'(OUTS_DEPTH - 1))
         return {~p[IDX_W], {IDX_W{1'b0}}};
      else
         return p + {{IDX_W{1'b0}}, 1'b1};
   endfunction

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                    (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
   assign push_en = push & ~full;
   assign pop_en  = pop & ~empty;
   assign pop_id  = mem[rd_ptr[IDX_W-1:0]];

   // Storage write; contents need no reset since empty gates every read.
   always_ff @(posedge clk) begin
      if (push_en)
         mem[wr_ptr[IDX_W-1:0]] <= push_id;
   end

   // Pointer update; simultaneous push and pop both take effect.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_en) wr_ptr <= ptr_inc(wr_ptr);
         if (pop_en)  rd_ptr <= ptr_inc(rd_ptr);
      end
   end

endmodule

// File: rtl/n101_subsys_icb_arb2.sv
// Two-master ICB arbiter: round-robin with bus-lock hold, in-order response routing.
module n101_subsys_icb_arb2
   import n101_subsys_icb_arb2_pkg::*;
#(
   parameter int OUTS_DEPTH = 2,
   parameter int OUTS_PTR_W = $clog2(OUTS_DEPTH) + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   // master 0
   input  logic                      m0_icb_cmd_valid,
   output logic                      m0_icb_cmd_ready,
   input  logic [N101_ADDR_SIZE-1:0] m0_icb_cmd_addr,
   input  logic                      m0_icb_cmd_read,
   input  logic [N101_XLEN-1:0]      m0_icb_cmd_wdata,
   input  logic [N101_XLEN/8-1:0]    m0_icb_cmd_wmask,
   input  logic                      m0_icb_cmd_lock,
   input  logic                      m0_icb_cmd_excl,
   input  logic [1:0]                m0_icb_cmd_size,
   output logic                      m0_icb_rsp_valid,
   input  logic                      m0_icb_rsp_ready,
   output logic                      m0_icb_rsp_err,
   output logic                      m0_icb_rsp_excl_ok,
   output logic [N101_XLEN-1:0]      m0_icb_rsp_rdata,
   // master 1
   input  logic                      m1_icb_cmd_valid,
   output logic                      m1_icb_cmd_ready,
   input  logic [N101_ADDR_SIZE-1:0] m1_icb_cmd_addr,
   input  logic                      m1_icb_cmd_read,
   input  logic [N101_XLEN-1:0]      m1_icb_cmd_wdata,
   input  logic [N101_XLEN/8-1:0]    m1_icb_cmd_wmask,
   input  logic                      m1_icb_cmd_lock,
   input  logic                      m1_icb_cmd_excl,
   input  logic [1:0]                m1_icb_cmd_size,
   output logic                      m1_icb_rsp_valid,
   input  logic                      m1_icb_rsp_ready,
   output logic                      m1_icb_rsp_err,
   output logic                      m1_icb_rsp_excl_ok,
   output logic [N101_XLEN-1:0]      m1_icb_rsp_rdata,
   // downstream slave port
   output logic                      o_icb_cmd_valid,
   input  logic                      o_icb_cmd_ready,
   output logic [N101_ADDR_SIZE-1:0] o_icb_cmd_addr,
   output logic                      o_icb_cmd_read,
   output logic [N101_XLEN-1:0]      o_icb_cmd_wdata,
   output logic [N101_XLEN/8-1:0]    o_icb_cmd_wmask,
   output logic                      o_icb_cmd_lock,
   output logic                      o_icb_cmd_excl,
   output logic [1:0]                o_icb_cmd_size,
   input  logic                      o_icb_rsp_valid,
   output logic                      o_icb_rsp_ready,
   input  logic                      o_icb_rsp_err,
   input  logic                      o_icb_rsp_excl_ok,
   input  logic [N101_XLEN-1:0]      o_icb_rsp_rdata
);

   logic     rr_ptr;
   logic     lock_vld;
   logic     lock_id;
   // hold_* remembers a granted-but-unaccepted command so the grant cannot move.
   logic     hold_vld;
   logic     hold_id;

   logic     grant;
   logic     gnt_valid;
   logic     accept;
   logic     fifo_full;
   logic     fifo_empty;
   logic     head_id;
   logic     rsp_pop;
   icb_cmd_t m0_cmd;
   icb_cmd_t m1_cmd;
   icb_cmd_t gnt_cmd;

   assign m0_cmd = '{addr: m0_icb_cmd_addr, read: m0_icb_cmd_read,
                     wdata: m0_icb_cmd_wdata, wmask: m0_icb_cmd_wmask,
                     lock: m0_icb_cmd_lock, excl: m0_icb_cmd_excl,
                     size: m0_icb_cmd_size};
   assign m1_cmd = '{addr: m1_icb_cmd_addr, read: m1_icb_cmd_read,
                     wdata: m1_icb_cmd_wdata, wmask: m1_icb_cmd_wmask,
                     lock: m1_icb_cmd_lock, excl: m1_icb_cmd_excl,
                     size: m1_icb_cmd_size};

   // Grant priority: bus lock, then a stalled grant, then round-robin / sole requester.
   always_comb begin
      grant = rr_ptr;
      if (lock_vld)
         grant = lock_id;
      else if (hold_vld)
         grant = hold_id;
      else if (m0_icb_cmd_valid && m1_icb_cmd_valid)
         grant = rr_ptr;
      else if (m0_icb_cmd_valid)
         grant = ARB_ID_M0;
      else if (m1_icb_cmd_valid)
         grant = ARB_ID_M1;
   end

   assign gnt_valid = (grant == ARB_ID_M1) ? m1_icb_cmd_valid : m0_icb_cmd_valid;
   assign gnt_cmd   = (grant == ARB_ID_M1) ? m1_cmd : m0_cmd;

   assign o_icb_cmd_valid  = gnt_valid & ~fifo_full;
   assign accept           = o_icb_cmd_valid & o_icb_cmd_ready;
   assign m0_icb_cmd_ready = (grant == ARB_ID_M0) & o_icb_cmd_ready & ~fifo_full;
   assign m1_icb_cmd_ready = (grant == ARB_ID_M1) & o_icb_cmd_ready & ~fifo_full;

   assign o_icb_cmd_addr  = gnt_cmd.addr;
   assign o_icb_cmd_read  = gnt_cmd.read;
   assign o_icb_cmd_wdata = gnt_cmd.wdata;
   assign o_icb_cmd_wmask = gnt_cmd.wmask;
   assign o_icb_cmd_lock  = gnt_cmd.lock;
   assign o_icb_cmd_excl  = gnt_cmd.excl;
   assign o_icb_cmd_size  = gnt_cmd.size;

   // Arbitration state: round-robin pointer moves and lock opens/closes only on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= ARB_ID_M0;
         lock_vld <= 1'b0;
         lock_id  <= ARB_ID_M0;
         hold_vld <= 1'b0;
         hold_id  <= ARB_ID_M0;
      end else begin
         hold_vld <= gnt_valid & ~accept;
         hold_id  <= grant;
         if (accept) begin
            if (gnt_cmd.lock) begin
               lock_vld <= 1'b1;
               lock_id  <= grant;
               if (!lock_vld) rr_ptr <= ~grant;
            end else if (lock_vld) begin
               lock_vld <= 1'b0;
               rr_ptr   <= ~lock_id;
            end else begin
               rr_ptr   <= ~grant;
            end
         end
      end
   end

   n101_subsys_arb_idfifo #(
      .OUTS_DEPTH (OUTS_DEPTH),
      .OUTS_PTR_W (OUTS_PTR_W)
   ) u_idfifo (
      .clk     (clk),
      .rst     (rst),
      .push    (accept),
      .push_id (grant),
      .pop     (rsp_pop),
      .pop_id  (head_id),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Responses return to the master recorded at the FIFO head; empty back-pressures.
   assign m0_icb_rsp_valid = o_icb_rsp_valid & ~fifo_empty & (head_id == ARB_ID_M0);
   assign m1_icb_rsp_valid = o_icb_rsp_valid & ~fifo_empty & (head_id == ARB_ID_M1);
   assign o_icb_rsp_ready  = ((head_id == ARB_ID_M1) ? m1_icb_rsp_ready : m0_icb_rsp_ready)
                             & ~fifo_empty;
   assign rsp_pop          = o_icb_rsp_valid & o_icb_rsp_ready;

   assign m0_icb_rsp_err     = o_icb_rsp_err;
   assign m0_icb_rsp_excl_ok = o_icb_rsp_excl_ok;
   assign m0_icb_rsp_rdata   = o_icb_rsp_rdata;
   assign m1_icb_rsp_err     = o_icb_rsp_err;
   assign m1_icb_rsp_excl_ok = o_icb_rsp_excl_ok;
   assign m1_icb_rsp_rdata   = o_icb_rsp_rdata;

endmodule

// File: tb/tb_n101_subsys_icb_arb2.sv
// Directed self-checking bench for the two-master ICB arbiter.
module tb_n101_subsys_icb_arb2;
   import n101_subsys_icb_arb2_pkg::*;

   logic clk = 1'b0;
   logic rst;

   logic                      m0_icb_cmd_valid, m0_icb_cmd_ready;
   logic [N101_ADDR_SIZE-1:0] m0_icb_cmd_addr;
   logic                      m0_icb_cmd_read;
   logic [N101_XLEN-1:0]      m0_icb_cmd_wdata;
   logic [N101_XLEN/8-1:0]    m0_icb_cmd_wmask;
   logic                      m0_icb_cmd_lock, m0_icb_cmd_excl;
   logic [1:0]                m0_icb_cmd_size;
   logic                      m0_icb_rsp_valid, m0_icb_rsp_ready;
   logic                      m0_icb_rsp_err, m0_icb_rsp_excl_ok;
   logic [N101_XLEN-1:0]      m0_icb_rsp_rdata;

   logic                      m1_icb_cmd_valid, m1_icb_cmd_ready;
   logic [N101_ADDR_SIZE-1:0] m1_icb_cmd_addr;
   logic                      m1_icb_cmd_read;
   logic [N101_XLEN-1:0]      m1_icb_cmd_wdata;
   logic [N101_XLEN/8-1:0]    m1_icb_cmd_wmask;
   logic                      m1_icb_cmd_lock, m1_icb_cmd_excl;
   logic [1:0]                m1_icb_cmd_size;
   logic                      m1_icb_rsp_valid, m1_icb_rsp_ready;
   logic                      m1_icb_rsp_err, m1_icb_rsp_excl_ok;
   logic [N101_XLEN-1:0]      m1_icb_rsp_rdata;

   logic                      o_icb_cmd_valid, o_icb_cmd_ready;
   logic [N101_ADDR_SIZE-1:0] o_icb_cmd_addr;
   logic                      o_icb_cmd_read;
   logic [N101_XLEN-1:0]      o_icb_cmd_wdata;
   logic [N101_XLEN/8-1:0]    o_icb_cmd_wmask;
   logic                      o_icb_cmd_lock, o_icb_cmd_excl;
   logic [1:0]                o_icb_cmd_size;
   logic                      o_icb_rsp_valid, o_icb_rsp_ready;
   logic                      o_icb_rsp_err, o_icb_rsp_excl_ok;
   logic [N101_XLEN-1:0]      o_icb_rsp_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   n101_subsys_icb_arb2 #(.OUTS_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
      .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
      .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
      .m0_icb_cmd_lock(m0_icb_cmd_lock), .m0_icb_cmd_excl(m0_icb_cmd_excl),
      .m0_icb_cmd_size(m0_icb_cmd_size),
      .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
      .m0_icb_rsp_err(m0_icb_rsp_err), .m0_icb_rsp_excl_ok(m0_icb_rsp_excl_ok),
      .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
      .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
      .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
      .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
      .m1_icb_cmd_lock(m1_icb_cmd_lock), .m1_icb_cmd_excl(m1_icb_cmd_excl),
      .m1_icb_cmd_size(m1_icb_cmd_size),
      .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
      .m1_icb_rsp_err(m1_icb_rsp_err), .m1_icb_rsp_excl_ok(m1_icb_rsp_excl_ok),
      .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
      .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready),
      .o_icb_cmd_addr(o_icb_cmd_addr), .o_icb_cmd_read(o_icb_cmd_read),
      .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_cmd_wmask(o_icb_cmd_wmask),
      .o_icb_cmd_lock(o_icb_cmd_lock), .o_icb_cmd_excl(o_icb_cmd_excl),
      .o_icb_cmd_size(o_icb_cmd_size),
      .o_icb_rsp_valid(o_icb_rsp_valid), .o_icb_rsp_ready(o_icb_rsp_ready),
      .o_icb_rsp_err(o_icb_rsp_err), .o_icb_rsp_excl_ok(o_icb_rsp_excl_ok),
      .o_icb_rsp_rdata(o_icb_rsp_rdata)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge, where inputs are changed.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_icb_cmd_valid = 1'b0; m0_icb_cmd_addr = '0; m0_icb_cmd_read = 1'b1;
      m0_icb_cmd_wdata = '0; m0_icb_cmd_wmask = '0; m0_icb_cmd_lock = 1'b0;
      m0_icb_cmd_excl = 1'b0; m0_icb_cmd_size = 2'd2; m0_icb_rsp_ready = 1'b1;
      m1_icb_cmd_valid = 1'b0; m1_icb_cmd_addr = '0; m1_icb_cmd_read = 1'b1;
      m1_icb_cmd_wdata = '0; m1_icb_cmd_wmask = '0; m1_icb_cmd_lock = 1'b0;
      m1_icb_cmd_excl = 1'b0; m1_icb_cmd_size = 2'd2; m1_icb_rsp_ready = 1'b1;
      o_icb_cmd_ready = 1'b1; o_icb_rsp_valid = 1'b0; o_icb_rsp_err = 1'b0;
      o_icb_rsp_excl_ok = 1'b0; o_icb_rsp_rdata = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      tick(); tick();
      rst = 1'b0;
      o_icb_rsp_valid = 1'b1;
      #1;
      n_checks++; if (m0_icb_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m0_rsp_valid: got %b want 0", m0_icb_rsp_valid); end
      n_checks++; if (m1_icb_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m1_rsp_valid: got %b want 0", m1_icb_rsp_valid); end
      n_checks++; if (o_icb_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_o_rsp_ready: got %b want 0", o_icb_rsp_ready); end
      n_checks++; if (o_icb_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_cmd_valid: got %b want 0", o_icb_cmd_valid); end
      o_icb_rsp_valid = 1'b0;
      tick();
   endtask

   // Both masters request continuously; grants alternate and responses follow in order.
   task automatic test_alternate();
      logic exp_g, exp_h;
      logic [31:0] exp_addr;
      m0_icb_cmd_addr = 32'h10;
      m1_icb_cmd_addr = 32'h20;
      for (int c = 0; c < 5; c++) begin
         m0_icb_cmd_valid = (c < 4);
         m1_icb_cmd_valid = (c < 4);
         o_icb_rsp_valid  = (c > 0);
         #1;
         if (c < 4) begin
            exp_g    = c[0];
            exp_addr = exp_g ? 32'h20 : 32'h10;
            n_checks++; if (o_icb_cmd_addr !== exp_addr) begin n_fail++; $display("FAIL alt_addr c%0d: got %h want %h", c, o_icb_cmd_addr, exp_addr); end
            n_checks++; if (m0_icb_cmd_ready !== ~exp_g) begin n_fail++; $display("FAIL alt_m0_ready c%0d: got %b want %b", c, m0_icb_cmd_ready, ~exp_g); end
            n_checks++; if (m1_icb_cmd_ready !== exp_g) begin n_fail++; $display("FAIL alt_m1_ready c%0d: got %b want %b", c, m1_icb_cmd_ready, exp_g); end
         end
         if (c > 0) begin
            exp_h = ~c[0];
            n_checks++; if (m1_icb_rsp_valid !== exp_h || m0_icb_rsp_valid !== ~exp_h) begin n_fail++; $display("FAIL alt_rsp_route c%0d: got m0=%b m1=%b want head %b", c, m0_icb_rsp_valid, m1_icb_rsp_valid, exp_h); end
         end
         tick();
      end
      idle_inputs();
   endtask

   // m1 holds a locked sequence; m0 is locked out until the unlocking beat is accepted.
   task automatic test_lock();
      // prime: lone m0 command so round-robin points at m1
      m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 32'h30;
      #1;
      n_checks++; if (m0_icb_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL lock_prime_m0_ready: got %b want 1", m0_icb_cmd_ready); end
      tick();
      // locked read from m1, response for the primed m0 command
      m1_icb_cmd_valid = 1'b1; m1_icb_cmd_addr = 32'h100; m1_icb_cmd_read = 1'b1; m1_icb_cmd_lock = 1'b1;
      o_icb_rsp_valid = 1'b1;
      #1;
      n_checks++; if (m0_icb_cmd_ready !== 1'b0 || m1_icb_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL lock_beat1_ready: got m0=%b m1=%b want m0=0 m1=1", m0_icb_cmd_ready, m1_icb_cmd_ready); end
      n_checks++; if (o_icb_cmd_lock !== 1'b1 || o_icb_cmd_addr !== 32'h100) begin n_fail++; $display("FAIL lock_beat1_fields: got lock=%b addr=%h want 1 100", o_icb_cmd_lock, o_icb_cmd_addr); end
      tick();
      // unlocking write; round-robin alone would now pick m0
      m1_icb_cmd_read = 1'b0; m1_icb_cmd_lock = 1'b0;
      #1;
      n_checks++; if (m0_icb_cmd_ready !== 1'b0 || m1_icb_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL lock_beat2_ready: got m0=%b m1=%b want m0=0 m1=1", m0_icb_cmd_ready, m1_icb_cmd_ready); end
      n_checks++; if (o_icb_cmd_read !== 1'b0) begin n_fail++; $display("FAIL lock_beat2_read: got %b want 0", o_icb_cmd_read); end
      n_checks++; if (m1_icb_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL lock_rsp_m1: got %b want 1", m1_icb_rsp_valid); end
      tick();
      // after unlock, m0 wins
      m1_icb_cmd_addr = 32'h104;
      #1;
      n_checks++; if (m0_icb_cmd_ready !== 1'b1 || m1_icb_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL lock_after_ready: got m0=%b m1=%b want m0=1 m1=0", m0_icb_cmd_ready, m1_icb_cmd_ready); end
      n_checks++; if (o_icb_cmd_addr !== 32'h30) begin n_fail++; $display("FAIL lock_after_addr: got %h want 30", o_icb_cmd_addr); end
      tick();
      m0_icb_cmd_valid = 1'b0; m1_icb_cmd_valid = 1'b0;
      #1;
      n_checks++; if (m0_icb_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL lock_drain_m0: got %b want 1", m0_icb_rsp_valid); end
      tick();
      idle_inputs();
   endtask

   // Stalled m0 command keeps the grant even though round-robin favours m1.
   task automatic test_backpressure();
      logic [31:0] got_addr;
      o_icb_cmd_ready = 1'b0;
      m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 32'h40;
      m1_icb_cmd_addr = 32'h50;
      for (int c = 0; c < 3; c++) begin
         m1_icb_cmd_valid = (c > 0);
         #1;
         got_addr = o_icb_cmd_addr;
         n_checks++; if (got_addr !== 32'h40 || o_icb_cmd_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold c%0d: got addr=%h valid=%b want 40 1", c, got_addr, o_icb_cmd_valid); end
         n_checks++; if (m0_icb_cmd_ready !== 1'b0 || m1_icb_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready c%0d: got m0=%b m1=%b want 0 0", c, m0_icb_cmd_ready, m1_icb_cmd_ready); end
         tick();
      end
      o_icb_cmd_ready = 1'b1;
      #1;
      n_checks++; if (m0_icb_cmd_ready !== 1'b1 || o_icb_cmd_addr !== 32'h40) begin n_fail++; $display("FAIL bp_release: got m0_ready=%b addr=%h want 1 40", m0_icb_cmd_ready, o_icb_cmd_addr); end
      tick();
      m0_icb_cmd_addr = 32'h44;
      #1;
      n_checks++; if (m1_icb_cmd_ready !== 1'b1 || m0_icb_cmd_ready !== 1'b0 || o_icb_cmd_addr !== 32'h50) begin n_fail++; $display("FAIL bp_next_m1: got m1=%b m0=%b addr=%h want 1 0 50", m1_icb_cmd_ready, m0_icb_cmd_ready, o_icb_cmd_addr); end
      tick();
      m0_icb_cmd_valid = 1'b0; m1_icb_cmd_valid = 1'b0;
      o_icb_rsp_valid = 1'b1;
      #1;
      n_checks++; if (m0_icb_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp0: got %b want 1", m0_icb_rsp_valid); end
      tick();
      n_checks++; if (m1_icb_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp1: got %b want 1", m1_icb_rsp_valid); end
      tick();
      idle_inputs();
   endtask

   // Two outstanding fill the FIFO; a pop frees space only for the following cycle.
   task automatic test_full();
      m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 32'h60;
      tick();
      m0_icb_cmd_addr = 32'h64;
      tick();
      m0_icb_cmd_addr = 32'h68;
      #1;
      n_checks++; if (m0_icb_cmd_ready !== 1'b0 || o_icb_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL full_block: got ready=%b valid=%b want 0 0", m0_icb_cmd_ready, o_icb_cmd_valid); end
      tick();
      o_icb_rsp_valid = 1'b1;
      #1;
      n_checks++; if (o_icb_rsp_ready !== 1'b1 || m0_icb_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL full_pop: got rsp_ready=%b m0_rsp_valid=%b want 1 1", o_icb_rsp_ready, m0_icb_rsp_valid); end
      n_checks++; if (m0_icb_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass: got %b want 0", m0_icb_cmd_ready); end
      tick();
      o_icb_rsp_valid = 1'b0;
      #1;
      n_checks++; if (m0_icb_cmd_ready !== 1'b1 || o_icb_cmd_addr !== 32'h68) begin n_fail++; $display("FAIL full_accept_next: got ready=%b addr=%h want 1 68", m0_icb_cmd_ready, o_icb_cmd_addr); end
      tick();
      m0_icb_cmd_valid = 1'b0;
      o_icb_rsp_valid = 1'b1;
      tick();
      #1;
      n_checks++; if (m0_icb_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL full_drain: got %b want 1", m0_icb_rsp_valid); end
      tick();
      idle_inputs();
   endtask

   // Exclusive read from m1 then m0 write; responses routed with their flags.
   task automatic test_rsp_excl();
      m1_icb_cmd_valid = 1'b1; m1_icb_cmd_addr = 32'h200; m1_icb_cmd_read = 1'b1;
      m1_icb_cmd_excl = 1'b1; m1_icb_cmd_size = 2'd1;
      #1;
      n_checks++; if (m1_icb_cmd_ready !== 1'b1 || o_icb_cmd_excl !== 1'b1 || o_icb_cmd_size !== 2'd1) begin n_fail++; $display("FAIL excl_cmd: got ready=%b excl=%b size=%0d want 1 1 1", m1_icb_cmd_ready, o_icb_cmd_excl, o_icb_cmd_size); end
      tick();
      m1_icb_cmd_valid = 1'b0;
      m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 32'h210; m0_icb_cmd_read = 1'b0;
      m0_icb_cmd_wdata = 32'hDEADBEEF; m0_icb_cmd_wmask = 4'b0110;
      #1;
      n_checks++; if (m0_icb_cmd_ready !== 1'b1 || o_icb_cmd_wdata !== 32'hDEADBEEF || o_icb_cmd_wmask !== 4'b0110 || o_icb_cmd_excl !== 1'b0) begin n_fail++; $display("FAIL excl_wr_cmd: got ready=%b wdata=%h wmask=%b excl=%b", m0_icb_cmd_ready, o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_cmd_excl); end
      tick();
      m0_icb_cmd_valid = 1'b0;
      m1_icb_rsp_ready = 1'b0;
      o_icb_rsp_valid = 1'b1; o_icb_rsp_excl_ok = 1'b1; o_icb_rsp_rdata = 32'h0000CAFE;
      #1;
      n_checks++; if (m1_icb_rsp_valid !== 1'b1 || m0_icb_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL excl_rsp_route: got m1=%b m0=%b want 1 0", m1_icb_rsp_valid, m0_icb_rsp_valid); end
      n_checks++; if (m1_icb_rsp_excl_ok !== 1'b1 || m1_icb_rsp_rdata !== 32'h0000CAFE) begin n_fail++; $display("FAIL excl_rsp_data: got excl_ok=%b rdata=%h want 1 cafe", m1_icb_rsp_excl_ok, m1_icb_rsp_rdata); end
      n_checks++; if (o_icb_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL excl_stall: got %b want 0", o_icb_rsp_ready); end
      tick();
      m1_icb_rsp_ready = 1'b1;
      #1;
      n_checks++; if (o_icb_rsp_ready !== 1'b1 || m1_icb_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL excl_release: got rsp_ready=%b m1_valid=%b want 1 1", o_icb_rsp_ready, m1_icb_rsp_valid); end
      tick();
      o_icb_rsp_excl_ok = 1'b0; o_icb_rsp_err = 1'b1;
      #1;
      n_checks++; if (m0_icb_rsp_valid !== 1'b1 || m1_icb_rsp_valid !== 1'b0 || m0_icb_rsp_err !== 1'b1) begin n_fail++; $display("FAIL err_rsp_m0: got m0=%b m1=%b err=%b want 1 0 1", m0_icb_rsp_valid, m1_icb_rsp_valid, m0_icb_rsp_err); end
      n_checks++; if (o_icb_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL err_rsp_ready: got %b want 1", o_icb_rsp_ready); end
      tick();
      idle_inputs();
   endtask

   // Reset with two locked commands outstanding clears FIFO, lock and round-robin.
   task automatic test_reset_mid();
      m0_icb_cmd_valid = 1'b1; m0_icb_cmd_lock = 1'b1; m0_icb_cmd_addr = 32'h300;
      tick();
      m0_icb_cmd_addr = 32'h304;
      tick();
      m0_icb_cmd_valid = 1'b0; m0_icb_cmd_lock = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      o_icb_rsp_valid = 1'b1;
      #1;
      n_checks++; if (m0_icb_rsp_valid !== 1'b0 || m1_icb_rsp_valid !== 1'b0 || o_icb_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_rsp: got m0=%b m1=%b rdy=%b want 0 0 0", m0_icb_rsp_valid, m1_icb_rsp_valid, o_icb_rsp_ready); end
      m1_icb_cmd_valid = 1'b1;
      #1;
      n_checks++; if (m1_icb_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_lock_clear: got m1_ready=%b want 1", m1_icb_cmd_ready); end
      m0_icb_cmd_valid = 1'b1;
      #1;
      n_checks++; if (m0_icb_cmd_ready !== 1'b1 || m1_icb_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_rr: got m0=%b m1=%b want 1 0", m0_icb_cmd_ready, m1_icb_cmd_ready); end
      m0_icb_cmd_valid = 1'b0; m1_icb_cmd_valid = 1'b0; o_icb_rsp_valid = 1'b0;
      tick();
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_alternate();
      test_lock();
      test_backpressure();
      test_full();
      test_rsp_excl();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
